// File: rtl/clk_period_monitor.sv
// clk_period_monitor: watches a divided (slow) clock from the fast clock_in
// domain. It synchronises the slow clock and turns its edges into one-cycle
// rise/fall strobes that downstream logic can use as clock enables. It also
// measures the slow period and high time in clock_in cycles, declares lock
// after a run of in-tolerance periods, and flags loss of the slow clock.
module clk_period_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 10,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             clk_slow,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  EXP_V     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  TOL_V     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  state_t state;
  state_t next_state;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist_ff;
  logic                   synced;
  logic                   rise_det;
  logic                   fall_det;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  deviation;
  logic              in_tol;
  logic              hit_timeout;

  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] next_lock;
  logic              next_timeout;
  logic              load_period;
  logic              load_high;

  assign synced   = sync_ff[SYNC_STAGES-1];
  assign rise_det = synced & ~hist_ff;
  assign fall_det = ~synced & hist_ff;

  // Synchroniser chain for the asynchronous slow clock plus one history flop
  // so that edges can be detected by comparing the last two synced samples.
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      sync_ff <= '0;
      hist_ff <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], clk_slow};
      hist_ff <= synced;
    end
  end

  // Registered edge strobes, one clock_in cycle wide per slow-clock edge.
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
    end
  end

  // Cycle counter restarting at 1 after each rise strobe, so on the next rise
  // strobe it holds the full period; it saturates rather than wrapping.
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rise_pulse) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Distance of the last published period from the expected one; evaluated
  // in the period_valid cycle so lock follows the published value.
  always_comb begin
    deviation = '0;
    if (period >= EXP_V) begin
      deviation = period - EXP_V;
    end else begin
      deviation = EXP_V - period;
    end
  end

  assign in_tol      = (deviation <= TOL_V);
  assign hit_timeout = (cnt == TIMEOUT_V) && !rise_pulse;

  // Next-state logic: arming on the first rise, lock qualification on each
  // published period, and loss detection when no rise arrives in time.
  always_comb begin
    next_state   = state;
    next_lock    = lock_cnt;
    next_timeout = timeout;
    load_period  = 1'b0;
    load_high    = 1'b0;
    case (state)
      IDLE: begin
        if (rise_pulse) begin
          next_state   = MEASURE;
          next_timeout = 1'b0;
          next_lock    = '0;
        end
      end
      MEASURE, LOCKED: begin
        load_period = rise_pulse;
        load_high   = fall_pulse;
        if (period_valid) begin
          if (in_tol) begin
            if (lock_cnt != LOCK_MAX) begin
              next_lock = lock_cnt + 1'b1;
            end
          end else begin
            next_lock = '0;
          end
          if (state == MEASURE && in_tol && next_lock == LOCK_MAX) begin
            next_state = LOCKED;
          end
          if (state == LOCKED && !in_tol) begin
            next_state = MEASURE;
          end
        end
        if (hit_timeout) begin
          next_state   = IDLE;
          next_timeout = 1'b1;
          next_lock    = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_lock  = '0;
      end
    endcase
  end

  // State register with lock counter, timeout flag and registered lock level.
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      timeout  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= next_state;
      lock_cnt <= next_lock;
      timeout  <= next_timeout;
      locked   <= (next_state == LOCKED);
    end
  end

  // Measurement registers; they hold their last values across a loss event.
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= load_period;
      if (load_period) begin
        period <= cnt;
      end
      if (load_high) begin
        high_time <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Testbench for clk_period_monitor: directed scenarios followed by random
// slow-clock waveforms, all checked every cycle against a reference model
// that works from slow-clock edge times rather than from register states.
module tb_clk_period_monitor;

  localparam int EXP   = 10;
  localparam int TOLV  = 1;
  localparam int LOCKN = 4;
  localparam int TMO   = 32;
  localparam int CMAX  = 255;
  localparam int DEPTH = 8192;

  logic       clock_in = 1'b0;
  logic       rst      = 1'b0;
  logic       clk_slow = 1'b0;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       period_valid;
  logic       locked;
  logic       timeout;
  logic [7:0] period;
  logic [7:0] high_time;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 1;
  int last_r = 0;
  int run   = 0;
  bit armed = 1'b0;
  bit lvl [DEPTH];

  int exp_period = 0;
  int exp_high   = 0;
  bit exp_pv      = 1'b0;
  bit exp_locked  = 1'b0;
  bit exp_timeout = 1'b0;

  int last_rp = 0;
  int to_at   = 0;
  int pv_seen = 0;
  int consec  = 0;
  bit prev_to = 1'b0;
  bit prev_rp = 1'b0;
  bit lat [4];
  int snap;
  int hlen;
  int llen;

  clk_period_monitor #(
    .SYNC_STAGES(2),
    .CNT_W(8),
    .EXP_PERIOD(EXP),
    .TOL(TOLV),
    .LOCK_COUNT(LOCKN),
    .TIMEOUT(TMO)
  ) dut (
    .clock_in(clock_in),
    .rst(rst),
    .clk_slow(clk_slow),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clock_in = ~clock_in;

  // Slow-clock level seen at posedge i; before the synchroniser restarts it
  // is treated as low.
  function automatic bit lv(input int i);
    if (i < base || i < 0 || i >= DEPTH) return 1'b0;
    return lvl[i];
  endfunction

  // A level change seen at posedge k becomes a strobe in cycle k+2,
  // i.e. the strobe is what posedge k+3 samples.
  function automatic bit exp_rise(input int c);
    return lv(c - 2) && !lv(c - 3);
  endfunction

  function automatic bit exp_fall(input int c);
    return !lv(c - 2) && lv(c - 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    check("rise_pulse",   32'(rise_pulse),   32'(exp_rise(cyc)));
    check("fall_pulse",   32'(fall_pulse),   32'(exp_fall(cyc)));
    check("period",       32'(period),       32'(exp_period));
    check("high_time",    32'(high_time),    32'(exp_high));
    check("period_valid", 32'(period_valid), 32'(exp_pv));
    check("locked",       32'(locked),       32'(exp_locked));
    check("timeout",      32'(timeout),      32'(exp_timeout));
  endtask

  task automatic modelReset();
    exp_period  = 0;
    exp_high    = 0;
    exp_pv      = 1'b0;
    exp_locked  = 1'b0;
    exp_timeout = 1'b0;
    armed       = 1'b0;
    run         = 0;
    last_r      = cyc;
    base        = cyc + 1;
  endtask

  // Advance the reference from cycle cyc to cyc+1. Elapsed cycles since the
  // last rise strobe is the measured quantity; lock means the last LOCKN
  // published periods were all within tolerance since arming.
  task automatic modelStep();
    bit er;
    bit ef;
    int cntv;
    int dev;
    bit n_pv;
    int n_period;
    int n_high;
    if (!rst) begin
      modelReset();
      return;
    end
    er   = exp_rise(cyc);
    ef   = exp_fall(cyc);
    cntv = cyc - last_r;
    if (cntv > CMAX) cntv = CMAX;
    n_pv     = er && armed;
    n_period = n_pv ? cntv : exp_period;
    n_high   = (ef && armed) ? cntv : exp_high;
    if (exp_pv) begin
      dev = exp_period - EXP;
      if (dev < 0) dev = -dev;
      run = (dev <= TOLV) ? run + 1 : 0;
    end
    if (armed && !er && cntv == TMO) begin
      armed       = 1'b0;
      exp_timeout = 1'b1;
      run         = 0;
    end else if (er && !armed) begin
      armed       = 1'b1;
      exp_timeout = 1'b0;
      run         = 0;
    end
    if (er) last_r = cyc;
    exp_pv     = n_pv;
    exp_period = n_period;
    exp_high   = n_high;
    exp_locked = armed && (run >= LOCKN);
  endtask

  task automatic tick();
    @(posedge clock_in);
    cyc++;
    if (cyc < DEPTH) lvl[cyc] = clk_slow;
    @(negedge clock_in);
    checkOutput();
    if (rise_pulse) last_rp = cyc;
    if (timeout && !prev_to) to_at = cyc;
    prev_to = timeout;
    if (period_valid) pv_seen++;
    if (fall_pulse && prev_rp) consec++;
    prev_rp = rise_pulse;
    modelStep();
  endtask

  task automatic applyStimulus(input bit level, input int n);
    clk_slow = level;
    repeat (n) tick();
  endtask

  task automatic slowCycle(input int h, input int l);
    applyStimulus(1'b1, h);
    applyStimulus(1'b0, l);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic asyncReset();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    check("async_rise",    32'(rise_pulse),   32'd0);
    check("async_fall",    32'(fall_pulse),   32'd0);
    check("async_period",  32'(period),       32'd0);
    check("async_high",    32'(high_time),    32'd0);
    check("async_valid",   32'(period_valid), 32'd0);
    check("async_locked",  32'(locked),       32'd0);
    check("async_timeout", 32'(timeout),      32'd0);
  endtask

  // Directed scenarios first, then random slow-clock waveforms.
  initial begin
    rst      = 1'b0;
    clk_slow = 1'b0;
    repeat (3) tick();
    check("reset_period", 32'(period), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 3);

    clk_slow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      lat[i] = rise_pulse;
    end
    check("latency_k",   32'(lat[0]), 32'd0);
    check("latency_k1",  32'(lat[1]), 32'd0);
    check("latency_k2",  32'(lat[2]), 32'd1);
    check("latency_k3",  32'(lat[3]), 32'd0);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 5);

    repeat (3) slowCycle(5, 5);
    check("prelock_locked", 32'(locked), 32'd0);
    slowCycle(5, 5);
    check("lock_locked", 32'(locked),    32'd1);
    check("lock_period", 32'(period),    32'd10);
    check("lock_high",   32'(high_time), 32'd5);

    slowCycle(6, 6);
    applyStimulus(1'b1, 5);
    check("jitter12_locked", 32'(locked), 32'd0);
    check("jitter12_period", 32'(period), 32'd12);
    applyStimulus(1'b0, 5);
    repeat (3) slowCycle(5, 5);
    check("relock_early", 32'(locked), 32'd0);
    slowCycle(5, 5);
    check("relock_locked", 32'(locked), 32'd1);

    slowCycle(5, 6);
    applyStimulus(1'b1, 5);
    check("jitter11_locked", 32'(locked), 32'd1);
    check("jitter11_period", 32'(period), 32'd11);
    applyStimulus(1'b0, 5);

    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 40);
    check("loss_timeout", 32'(timeout),         32'd1);
    check("loss_locked",  32'(locked),          32'd0);
    check("loss_period",  32'(period),          32'd10);
    check("loss_delay",   32'(to_at - last_rp), 32'd33);
    snap = pv_seen;
    slowCycle(5, 5);
    check("rearm_no_valid", 32'(pv_seen), 32'(snap));
    check("rearm_timeout",  32'(timeout), 32'd0);

    repeat (4) slowCycle(5, 5);
    check("lock2_locked", 32'(locked), 32'd1);
    slowCycle(5, 27);
    applyStimulus(1'b1, 5);
    check("edge32_timeout", 32'(timeout), 32'd0);
    check("edge32_period",  32'(period),  32'd32);
    check("edge32_locked",  32'(locked),  32'd0);
    applyStimulus(1'b0, 5);

    repeat (4) slowCycle(5, 5);
    check("prereset_locked", 32'(locked), 32'd1);
    slowCycle(5, 2);
    asyncReset();
    applyStimulus(1'b0, 3);
    rst  = 1'b1;
    snap = pv_seen;
    slowCycle(5, 5);
    check("post_reset_arm",   32'(pv_seen), 32'(snap));
    slowCycle(5, 5);
    check("post_reset_valid", 32'(pv_seen), 32'(snap + 1));

    snap = consec;
    slowCycle(1, 9);
    slowCycle(1, 9);
    check("narrow_high",   32'(high_time), 32'd1);
    check("narrow_consec", 32'(consec),    32'(snap + 2));

    repeat (80) begin
      hlen = int'($urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) llen = int'($urandom_range(25, 45));
      else llen = int'($urandom_range(1, 12));
      slowCycle(hlen, llen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_period_monitor.md
# clk_period_monitor

Fast-domain monitor for a divided clock. Synchronises a slow clock into the `clock_in` domain and emits one-cycle rise and fall strobes. Measures period and high time in `clock_in` cycles, declares lock after repeated in-tolerance periods, and flags loss of the slow clock. Consumer side of the FFT datapath's clock divider: butterfly stages use its strobes as clock enables instead of clocking on the divided clock directly.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `clk_slow`; minimum 2.
- `CNT_W`, 8: width of the cycle counter, `period` and `high_time`.
- `EXP_PERIOD`, 10: expected slow period in `clock_in` cycles.
- `TOL`, 1: allowed period deviation, ± cycles, inclusive.
- `LOCK_COUNT`, 4: consecutive in-tolerance periods required for lock.
- `TIMEOUT`, 32: cycles without a rise before loss is declared; must be < 2^CNT_W.

- `clock_in`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clk_slow`  in  1  monitored clock, treated as asynchronous.
- `rise_pulse`  out  1  one-cycle strobe per detected rising edge of `clk_slow`.
- `fall_pulse`  out  1  one-cycle strobe per detected falling edge.
- `period`  out  CNT_W  last measured period.
- `high_time`  out  CNT_W  last measured high time.
- `period_valid`  out  1  one-cycle strobe when `period` updates.
- `locked`  out  1  level; period stable within tolerance.
- `timeout`  out  1  level; no rise seen for TIMEOUT cycles.

## Operation
- `clk_slow` passes through SYNC_STAGES flops, then one history flop.
- Rise: synced=1, history=0. Fall: synced=0, history=1. Strobes are registered.
- Cycle counter `cnt`:
  - Rise cycle: `cnt` <= 1.
  - Otherwise: `cnt` <= `cnt`+1, saturating at all-ones.
- FSM states IDLE, MEASURE, LOCKED; reset state IDLE.
- IDLE:
  - First rise: go to MEASURE, clear `timeout`, clear lock counter.
  - No `period` update and no `period_valid` in this state.
- MEASURE / LOCKED, on each rise:
  - `period` <= `cnt`; `period_valid` pulses.
  - In tolerance means |`cnt` − EXP_PERIOD| ≤ TOL. If in tolerance, the lock counter increments, saturating at LOCK_COUNT. Otherwise it clears.
  - MEASURE goes to LOCKED when the counter reaches LOCK_COUNT.
  - LOCKED goes to MEASURE on any out-of-tolerance period.
- On each fall outside IDLE: `high_time` <= `cnt`.
- Loss: outside IDLE, if `cnt` == TIMEOUT and no rise this cycle:
  - Go to IDLE, set `timeout`, clear lock counter.
  - `period` and `high_time` hold their last values.
- `locked` = (state == LOCKED), registered.
- Simultaneous events:
  - Rise in the same cycle as `cnt` == TIMEOUT: the rise wins, no timeout.
  - A rise and a fall in the same cycle cannot occur, because the history flop is single.

## Timing
- Reset values: all outputs 0, `cnt` = 0, state IDLE, synchroniser flops 0.
- Reset asserted mid-operation clears everything immediately. After release, the first rise only arms; no `period_valid` for it.
- Strobe latency: an edge on `clk_slow` that is sampled at edge k gives a strobe at edge k+SYNC_STAGES+1. Default: 3 cycles.
- `period` / `high_time` update on the strobe cycle, visible the following cycle.
- `period_valid` is coincident with that update: asserted in the cycle after the `rise_pulse` cycle.
- `locked` asserts the cycle after the LOCK_COUNT-th in-tolerance `period_valid`, and deasserts the cycle after the failing `period_valid`.
- `timeout` asserts TIMEOUT+1 cycles after the last rise strobe, and clears the cycle after the next rise strobe.
- With a 50% divide-by-10 input (5 high, 5 low), `rise_pulse` and `fall_pulse` are each 1 cycle wide, 5 cycles apart.

## Test plan
- Divide-by-10, 50% duty, default parameters:
  - `period_valid` every 10 cycles with `period`=10 and `high_time`=5.
  - `locked`=1 after the 5th rise strobe (1 arming rise + 4 periods).
- Period jitter while locked: one 12-cycle period → `locked` drops the cycle after that `period_valid`. Then 4 periods of 10 → relock. An 11-cycle period keeps lock (TOL=1).
- Stop `clk_slow` low while locked:
  - `timeout`=1 and `locked`=0 exactly 33 cycles after the last `rise_pulse`.
  - `period` keeps 10.
  - The next rise clears `timeout` and produces no `period_valid`.
- Rise arriving exactly at `cnt`=32: no `timeout`, `period`=32, and `locked` clears.
- Assert `rst` mid-period while locked: all outputs 0 asynchronously. After release, the first rise gives no `period_valid` and the second rise gives `period_valid`.
- Glitch-free edge latency: toggle `clk_slow` one cycle before a `clock_in` edge → strobe exactly 3 cycles after the sampling edge. A 1-cycle-high pulse on `clk_slow` → `rise_pulse` then `fall_pulse` on consecutive cycles with `high_time`=1.
